// File: rtl/uart_tx_fifo_drain.sv
`timescale 1ns/1ps
// Drains a registered-output byte FIFO onto an 8N1 UART line, one pop per frame.
// Pop to start-bit edge is 2 cycles; tx_enable only gates new frames, a started frame always completes.
module uart_tx_fifo_drain #(
  parameter int CLOCK_FREQ          = 125_000_000,
  parameter int BAUD_RATE           = 115_200,
  parameter int WIDTH               = 8,
  parameter int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE,
  parameter int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_rd_en,
  input  logic             tx_enable,
  output logic             serial_out,
  output logic             busy,
  output logic             tx_done
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ   = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] DATA  = 3'd4;
  localparam logic [2:0] STOP  = 3'd5;

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [CLOCK_COUNTER_WIDTH-1:0] CNT_LAST = CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  logic [2:0]                     state;
  logic [WIDTH-1:0]               shift;
  logic [BIT_W-1:0]               bit_cnt;
  logic [CLOCK_COUNTER_WIDTH-1:0] clk_cnt;
  logic                           period_end;
  logic                           launch;

  assign period_end = (clk_cnt == CNT_LAST);
  assign launch     = tx_enable && !fifo_empty;
  assign fifo_rd_en = (state == REQ);
  assign busy       = (state != IDLE);
  assign tx_done    = (state == STOP) && period_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      serial_out <= 1'b1;
      shift      <= '0;
      bit_cnt    <= '0;
      clk_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          if (launch) state <= REQ;
        end
        REQ: state <= WAIT;
        // Registered FIFO output is valid here, one cycle after the pop.
        WAIT: begin
          shift      <= fifo_dout;
          clk_cnt    <= '0;
          serial_out <= 1'b0;
          state      <= START;
        end
        START: begin
          if (period_end) begin
            clk_cnt    <= '0;
            serial_out <= shift[0];
            bit_cnt    <= '0;
            state      <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (period_end) begin
            clk_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              serial_out <= 1'b1;
              state      <= STOP;
            end else begin
              shift      <= shift >> 1;
              serial_out <= shift[1];
              bit_cnt    <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (period_end) begin
            clk_cnt <= '0;
            state   <= launch ? REQ : IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          serial_out <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
`timescale 1ns/1ps
// Directed bench for uart_tx_fifo_drain at 10 cycles/bit with a registered-output FIFO model.
module tb_uart_tx_fifo_drain;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en, serial_out, busy, tx_done;

  logic [7:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int tests  = 0;
  int failed = 0;

  uart_tx_fifo_drain #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .tx_enable(tx_enable), .serial_out(serial_out),
    .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
      rd_cnt    <= rd_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[7:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_rd(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (fifo_rd_en === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_start(input int lim, output logic ok, output int highs);
    ok = 1'b0;
    highs = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (serial_out === 1'b0) ok = 1'b1;
      else highs++;
    end
  endtask

  // Entered at the negedge of the first start-bit cycle; samples all 100 frame cycles.
  task automatic rx_frame(input int drop_at, output logic [7:0] d, output logic ferr, output logic dn_ok);
    logic [99:0] line, dn;
    for (int c = 0; c < 100; c++) begin
      if (c > 0) @(negedge clk);
      if (c == drop_at) tx_enable = 1'b0;
      line[c] = serial_out;
      dn[c]   = tx_done;
    end
    ferr = 1'b0;
    for (int p = 0; p < 10; p++)
      for (int j = 0; j < 10; j++)
        if (line[10*p+j] !== line[10*p]) ferr = 1'b1;
    if (line[0] !== 1'b0 || line[90] !== 1'b1) ferr = 1'b1;
    for (int b = 0; b < 8; b++) d[b] = line[10*(b+1)+5];
    dn_ok = (dn === {1'b1, 99'b0});
  endtask

  logic       ok, fe, dn;
  logic [7:0] d;
  logic [7:0] exp6 [32];
  logic [7:0] exp3 [3];
  int         h, rc, bad;

  initial begin
    // Reset state
    #12;
    check("rst_serial_out", serial_out, 1);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);

    // 1: empty FIFO, enabled, 200 cycles idle
    @(negedge clk);
    tx_enable = 1'b1;
    rst = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("t1_idle_violations", bad, 0);

    // 2: single byte 0xA5 with exact latency
    rc = rd_cnt;
    push(8'hA5);
    wait_rd(10, ok);
    check("t2_rd_en_seen", ok, 1);
    @(negedge clk);
    check("t2_wait_line_high", serial_out, 1);
    check("t2_rd_en_one_cycle", fifo_rd_en, 0);
    @(negedge clk);
    check("t2_start_low_k2", serial_out, 0);
    rx_frame(-1, d, fe, dn);
    check("t2_data", d, 8'hA5);
    check("t2_framing_err", fe, 0);
    check("t2_tx_done_at_100", dn, 1);
    @(negedge clk);
    check("t2_busy_falls", busy, 0);
    check("t2_pop_count", rd_cnt - rc, 1);

    // 3: three back-to-back bytes
    rc = rd_cnt;
    exp3[0] = 8'h00; exp3[1] = 8'hFF; exp3[2] = 8'h3C;
    for (int i = 0; i < 3; i++) push(exp3[i]);
    for (int i = 0; i < 3; i++) begin
      wait_start(30, ok, h);
      check($sformatf("t3_start%0d", i), ok, 1);
      if (i > 0) check($sformatf("t3_gap%0d", i), 10 + h, 12);
      rx_frame(-1, d, fe, dn);
      check($sformatf("t3_data%0d", i), d, exp3[i]);
      check($sformatf("t3_ferr%0d", i), fe, 0);
    end
    @(negedge clk);
    check("t3_busy_falls", busy, 0);
    check("t3_pop_count", rd_cnt - rc, 3);

    // 4: tx_enable gating and mid-frame drop
    tx_enable = 1'b0;
    rc = rd_cnt;
    push(8'h12);
    push(8'h34);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t4_held_idle", bad, 0);
    check("t4_no_pop_disabled", rd_cnt - rc, 0);
    tx_enable = 1'b1;
    wait_start(20, ok, h);
    check("t4_start", ok, 1);
    rx_frame(50, d, fe, dn);
    check("t4_data", d, 8'h12);
    check("t4_ferr", fe, 0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (serial_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("t4_idle_after_drop", bad, 0);
    check("t4_one_pop", rd_cnt - rc, 1);
    check("t4_second_queued", wr_ptr - rd_ptr, 1);
    tx_enable = 1'b1;
    wait_start(20, ok, h);
    rx_frame(-1, d, fe, dn);
    check("t4_resume_data", d, 8'h34);

    // 5: asynchronous reset in DATA bit 3 of 0x55
    rc = rd_cnt;
    push(8'h55);
    push(8'h66);
    wait_start(30, ok, h);
    check("t5_start", ok, 1);
    repeat (44) @(negedge clk);
    check("t5_bit3_low", serial_out, 0);
    rst = 1'b0;
    #1;
    check("t5_async_line_high", serial_out, 1);
    check("t5_async_busy", busy, 0);
    check("t5_async_rd_en", fifo_rd_en, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_start(30, ok, h);
    check("t5_restart", ok, 1);
    rx_frame(-1, d, fe, dn);
    check("t5_next_byte", d, 8'h66);
    check("t5_ferr", fe, 0);
    check("t5_pop_count", rd_cnt - rc, 2);
    check("t5_fifo_drained", wr_ptr - rd_ptr, 0);

    // 6: 32 random bytes at random intervals
    for (int i = 0; i < 32; i++) exp6[i] = 8'($urandom_range(0, 255));
    rc = rd_cnt;
    bad = 0;
    fork
      begin
        for (int i = 0; i < 32; i++) begin
          repeat ($urandom_range(1, 150)) @(negedge clk);
          push(exp6[i]);
        end
      end
      begin
        for (int i = 0; i < 32; i++) begin
          wait_start(400, ok, h);
          check($sformatf("t6_start%0d", i), ok, 1);
          if (ok) begin
            rx_frame(-1, d, fe, dn);
            check($sformatf("t6_byte%0d", i), d, exp6[i]);
            if (fe || !dn) bad++;
          end
        end
      end
    join
    check("t6_framing_errors", bad, 0);
    check("t6_pop_count", rd_cnt - rc, 32);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
- Consumer stage that sits directly downstream of the io_circuits byte FIFO and drains it onto a UART serial line.
- Pops one byte whenever the FIFO is non-empty and transmission is enabled.
- The FIFO's dout is registered, so the popped byte is valid one cycle after the pop.
- Each byte is serialized as 8N1: start bit, WIDTH data bits LSB first, one stop bit. The line idles high.

Parameters:
- CLOCK_FREQ, 125_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in bits per second.
- WIDTH, 8: data bits per frame; must match the FIFO WIDTH.
- SYMBOL_EDGE_TIME, CLOCK_FREQ/BAUD_RATE: clock cycles per bit. Integer division; must be >= 2.
- CLOCK_COUNTER_WIDTH, $clog2(SYMBOL_EDGE_TIME): width of the bit-period counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  WIDTH  FIFO read data; valid the cycle after a pop.
- fifo_rd_en  output  1  pop request to the FIFO; high for exactly one cycle per byte.
- tx_enable  input  1  flow control; gates the start of new frames only.
- serial_out  output  1  UART TX line, registered.
- busy  output  1  high whenever state != IDLE.
- tx_done  output  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, serial_out=1, fifo_rd_en=0, busy=0, tx_done=0.
  - Shift register, bit counter and clock counter all =0.
  - Reset asserted mid-frame forces the line high immediately; the partial frame is abandoned and the FIFO is not popped again.
- States: IDLE, REQ, WAIT, START, DATA, STOP.
- IDLE:
  - serial_out=1.
  - If tx_enable && !fifo_empty, go to REQ next cycle; otherwise stay.
- REQ (1 cycle):
  - fifo_rd_en=1, decoded from state. It is never high in any other state.
  - Next state WAIT.
- WAIT (1 cycle):
  - fifo_dout is valid during this cycle.
  - At the closing edge, latch fifo_dout into the shift register, clear the clock counter, drive serial_out=0, and go to START.
- START:
  - serial_out=0 for SYMBOL_EDGE_TIME cycles.
  - Then drive shift[0] onto serial_out, set bit counter=0, go to DATA.
- DATA:
  - Each bit is held for SYMBOL_EDGE_TIME cycles.
  - At each period end, shift right and increment the bit counter.
  - After WIDTH bits, drive serial_out=1 and go to STOP.
- STOP:
  - serial_out=1 for SYMBOL_EDGE_TIME cycles.
  - On the last cycle, assert tx_done for one cycle.
  - Then go directly to REQ if tx_enable && !fifo_empty; otherwise go to IDLE.
- Clock counter: counts 0..SYMBOL_EDGE_TIME-1 and wraps to 0 at each bit boundary.
- Latency:
  - fifo_rd_en high in cycle k.
  - serial_out falls at the edge ending cycle k+1 and is low from cycle k+2.
  - Frame length is (WIDTH+2)*SYMBOL_EDGE_TIME cycles.
- Back-to-back frames: the line stays high for SYMBOL_EDGE_TIME+2 cycles between frames (stop bit, REQ, WAIT).
- Boundary conditions:
  - fifo_empty=1: never pop; fifo_rd_en stays 0 even if tx_enable=1.
  - fifo_empty is sampled only in IDLE or at the end of STOP; a FIFO write during a frame is picked up at the next decision point.
  - tx_enable dropped mid-frame: the current frame completes, then the block returns to IDLE.
  - tx_enable and fifo_empty are ignored in every state other than IDLE and the end of STOP.
  - Exactly one pop per transmitted byte; no byte is lost or duplicated across frames.

Test Plan (CLOCK_FREQ=1000, BAUD_RATE=100 → 10 cycles/bit):
1. Release reset with the FIFO empty and tx_enable=1 for 200 cycles -> serial_out=1, fifo_rd_en=0, busy=0 throughout.
2. Push 0xA5 into the FIFO -> one fifo_rd_en pulse; serial_out low 2 cycles later. Line carries 0 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then 1 for 10 cycles. tx_done pulses once at cycle 100 of the frame. busy then falls.
3. Push 0x00, 0xFF, 0x3C back-to-back -> exactly 3 rd_en pulses. The three frames decode to 0x00, 0xFF, 0x3C in order, with a 12-cycle high gap between frames.
4. Hold tx_enable=0 with 2 bytes queued -> no pop. Raise tx_enable -> first frame starts. Drop tx_enable mid-way through the first frame's data -> that frame completes, second byte is not popped, block sits in IDLE.
5. Assert rst during DATA bit 3 of 0x55 -> serial_out=1 the same cycle (asynchronous), busy=0. After release, the next queued byte transmits cleanly and 0x55 is not resent.
6. Bench-side UART receiver model checks 32 random bytes written at random intervals -> all 32 received in order, no framing errors, rd_en pulse count = 32.
